// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin N-master arbiter in front of the single memory controller port
// One transaction in flight; requests are captured in IDLE and replayed to the controller from issue registers.
module memory_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mDataWrite,
  input  logic [NUM_MASTERS*2-1:0]          mLength,
  input  logic [NUM_MASTERS-1:0]            mStore,
  input  logic [NUM_MASTERS-1:0]            mLoad,
  input  logic [NUM_MASTERS-1:0]            mLoadUnsigned,
  output logic [NUM_MASTERS-1:0]            mAck,
  output logic [NUM_MASTERS-1:0]            mGrant,
  output logic [DATA_WIDTH-1:0]             mDataRead,
  output logic                              protocolError,
  output logic [DATA_WIDTH-1:0]             ctrlAddress,
  output logic [DATA_WIDTH-1:0]             ctrlDataWrite,
  output logic [1:0]                        ctrlLength,
  output logic                              ctrlStore,
  output logic                              ctrlLoad,
  output logic                              ctrlLoadUnsigned,
  input  logic [DATA_WIDTH-1:0]             ctrlDataRead
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                  state;
  logic [PW-1:0]           rr_ptr;
  logic [NUM_MASTERS-1:0]  grant;
  logic [DATA_WIDTH-1:0]   iss_addr;
  logic [DATA_WIDTH-1:0]   iss_data;
  logic [1:0]              iss_len;
  logic                    iss_unsigned;
  logic                    iss_store;
  logic [CW-1:0]           wait_cnt;
  logic                    perr;

  logic [NUM_MASTERS-1:0]  req;
  logic                    any_req;
  logic [PW-1:0]           winner;
  logic [PW-1:0]           scan_idx;

  assign req     = mStore | mLoad;
  assign any_req = |req;

  // Scan from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      scan_idx = PW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (req[scan_idx]) winner = scan_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= PW'(NUM_MASTERS - 1);
      grant        <= '0;
      iss_addr     <= '0;
      iss_data     <= '0;
      iss_len      <= '0;
      iss_unsigned <= 1'b0;
      iss_store    <= 1'b0;
      wait_cnt     <= '0;
      perr         <= 1'b0;
    end else begin
      if (|(mStore & mLoad)) perr <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            rr_ptr       <= winner;
            grant        <= NUM_MASTERS'(1) << winner;
            iss_addr     <= mAddress[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            iss_data     <= mDataWrite[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            iss_len      <= mLength[int'(winner)*2 +: 2];
            iss_unsigned <= mLoadUnsigned[winner];
            // Store takes priority when both op bits are set.
            iss_store    <= mStore[winner];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (iss_store) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            wait_cnt <= CW'(READ_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic active;
  logic ack;
  logic load_done;

  assign active    = (state != IDLE);
  assign load_done = (state == WAIT) && (wait_cnt == '0);
  assign ack       = ((state == ISSUE) && iss_store) || load_done;

  assign mAck             = ack ? grant : '0;
  assign mGrant           = grant;
  assign mDataRead        = load_done ? ctrlDataRead : '0;
  assign protocolError    = perr;
  assign ctrlAddress      = active ? iss_addr : '0;
  assign ctrlDataWrite    = active ? iss_data : '0;
  assign ctrlLength       = active ? iss_len : 2'b00;
  assign ctrlLoadUnsigned = active & iss_unsigned;
  assign ctrlStore        = (state == ISSUE) & iss_store;
  assign ctrlLoad         = (state == ISSUE) & ~iss_store;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter (3 masters, read latency 3)
module tb_memory_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int RL = 3;

  logic          clk = 0;
  logic          reset = 1;
  logic [N*DW-1:0] m_address = '0;
  logic [N*DW-1:0] m_data_write = '0;
  logic [N*2-1:0]  m_length = '0;
  logic [N-1:0]    m_store = '0;
  logic [N-1:0]    m_load = '0;
  logic [N-1:0]    m_unsigned = '0;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_grant;
  logic [DW-1:0]   m_data_read;
  logic            protocol_error;
  logic [DW-1:0]   ctrl_address;
  logic [DW-1:0]   ctrl_data_write;
  logic [1:0]      ctrl_length;
  logic            ctrl_store;
  logic            ctrl_load;
  logic            ctrl_load_unsigned;
  logic [DW-1:0]   ctrl_data_read;

  // Controller model: fixed word at 0x40, inverted address elsewhere.
  assign ctrl_data_read = (ctrl_address == 32'h40) ? 32'h1234_5678 : ~ctrl_address;

  memory_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .mAddress(m_address), .mDataWrite(m_data_write), .mLength(m_length),
    .mStore(m_store), .mLoad(m_load), .mLoadUnsigned(m_unsigned),
    .mAck(m_ack), .mGrant(m_grant), .mDataRead(m_data_read),
    .protocolError(protocol_error),
    .ctrlAddress(ctrl_address), .ctrlDataWrite(ctrl_data_write), .ctrlLength(ctrl_length),
    .ctrlStore(ctrl_store), .ctrlLoad(ctrl_load), .ctrlLoadUnsigned(ctrl_load_unsigned),
    .ctrlDataRead(ctrl_data_read)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int master; logic [31:0] data; int cycle; } ack_t;
  typedef struct { logic store; logic [31:0] addr; logic [31:0] wdata; logic [1:0] len; logic uns; int cycle; } iss_t;
  ack_t ack_q[$];
  iss_t iss_q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT acks or issues to the controller.
  ack_t a;
  iss_t s;
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_ack) chk("grant_zero_after_ack", 32'(m_grant), 32'h0);
      if (m_ack != '0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", 32'(m_ack), 32'h0);
        else begin
          a = ack_q.pop_front();
          chk("ack_onehot", 32'(m_ack), 32'(1) << a.master);
          chk("ack_grant", 32'(m_grant), 32'(1) << a.master);
          chk("ack_rdata", m_data_read, a.data);
          chk("ack_cycle", 32'(cyc), 32'(a.cycle));
        end
      end else begin
        chk("rdata_zero", m_data_read, 32'h0);
      end
      if (ctrl_store | ctrl_load) begin
        if (iss_q.size() == 0) chk("unexpected_issue", {30'b0, ctrl_store, ctrl_load}, 32'h0);
        else begin
          s = iss_q.pop_front();
          chk("iss_store", 32'(ctrl_store), 32'(s.store));
          chk("iss_load", 32'(ctrl_load), 32'(!s.store));
          chk("iss_addr", ctrl_address, s.addr);
          chk("iss_wdata", ctrl_data_write, s.wdata);
          chk("iss_len", 32'(ctrl_length), 32'(s.len));
          chk("iss_unsigned", 32'(ctrl_load_unsigned), 32'(s.uns));
          chk("iss_cycle", 32'(cyc), 32'(s.cycle));
        end
      end
      prev_ack = (m_ack != '0);
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic set_master(input int i, input logic st, input logic ld, input logic uns,
                            input logic [31:0] addr, input logic [31:0] data, input logic [1:0] len);
    m_store[i] = st;
    m_load[i] = ld;
    m_unsigned[i] = uns;
    m_address[i*DW +: DW] = addr;
    m_data_write[i*DW +: DW] = data;
    m_length[i*2 +: 2] = len;
  endtask

  task automatic clear_master(input int i);
    set_master(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  task automatic push_iss(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] len, input logic uns, input int c);
    iss_t e;
    e.store = st; e.addr = addr; e.wdata = wd; e.len = len; e.uns = uns; e.cycle = c;
    iss_q.push_back(e);
  endtask

  task automatic push_ack(input int m, input logic [31:0] d, input int c);
    ack_t e;
    e.master = m; e.data = d; e.cycle = c;
    ack_q.push_back(e);
  endtask

  task automatic wait_ack(input int i);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (m_ack[i]) break;
      n++;
    end
    chk($sformatf("ack_wait_m%0d", i), 32'(n < 50), 32'h1);
  endtask

  // Expects reset to be high already; checks the cleared outputs and releases reset.
  task automatic reset_check();
    @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(m_ack), 32'h0);
    chk("rst_grant", 32'(m_grant), 32'h0);
    chk("rst_rdata", m_data_read, 32'h0);
    chk("rst_caddr", ctrl_address, 32'h0);
    chk("rst_cwdata", ctrl_data_write, 32'h0);
    chk("rst_clen", 32'(ctrl_length), 32'h0);
    chk("rst_cops", {29'b0, ctrl_store, ctrl_load, ctrl_load_unsigned}, 32'h0);
    chk("rst_perr", 32'(protocol_error), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int k;
  initial begin
    reset_check();
    repeat (2) step();

    // Master 0 store
    k = cyc;
    set_master(0, 1, 0, 0, 32'h100, 32'hDEAD_BEEF, 2'd2);
    push_iss(1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0, k + 1);
    push_ack(0, 32'h0, k + 1);
    wait_ack(0);
    clear_master(0);
    repeat (2) step();

    // Master 1 load, latency 3
    k = cyc;
    set_master(1, 0, 1, 1, 32'h40, 32'h0BAD_F00D, 2'd2);
    push_iss(0, 32'h40, 32'h0BAD_F00D, 2'd2, 1, k + 1);
    push_ack(1, 32'h1234_5678, k + 4);
    wait_ack(1);
    clear_master(1);
    repeat (2) step();

    // Fresh reset, then all masters storing continuously
    reset = 1'b1;
    reset_check();
    step();
    k = cyc;
    for (int i = 0; i < N; i++) set_master(i, 1, 0, 0, 32'h200 + 32'(i*4), 32'hA000_0000 + 32'(i), 2'(i));
    for (int t = 0; t < 6; t++) begin
      push_iss(1, 32'h200 + 32'((t%3)*4), 32'hA000_0000 + 32'(t%3), 2'(t%3), 0, k + 1 + 2*t);
      push_ack(t % 3, 32'h0, k + 1 + 2*t);
    end
    for (int t = 0; t < 6; t++) wait_ack(t % 3);
    for (int i = 0; i < N; i++) clear_master(i);
    repeat (2) step();

    // Both op bits: store performed, error sticks through a clean transaction
    chk("perr_before", 32'(protocol_error), 32'h0);
    k = cyc;
    set_master(0, 1, 1, 0, 32'h500, 32'h55AA_55AA, 2'd1);
    push_iss(1, 32'h500, 32'h55AA_55AA, 2'd1, 0, k + 1);
    push_ack(0, 32'h0, k + 1);
    wait_ack(0);
    clear_master(0);
    chk("perr_set", 32'(protocol_error), 32'h1);
    step();
    k = cyc;
    set_master(1, 1, 0, 0, 32'h504, 32'h1111_2222, 2'd0);
    push_iss(1, 32'h504, 32'h1111_2222, 2'd0, 0, k + 1);
    push_ack(1, 32'h0, k + 1);
    wait_ack(1);
    clear_master(1);
    repeat (2) step();
    chk("perr_sticky", 32'(protocol_error), 32'h1);

    // Reset during WAIT of a master 0 load: no ack, error cleared
    k = cyc;
    set_master(0, 0, 1, 0, 32'h600, 32'h0, 2'd0);
    push_iss(0, 32'h600, 32'h0, 2'd0, 0, k + 1);
    step();
    step();
    reset = 1'b1;
    clear_master(0);
    reset_check();
    repeat (6) step();

    // Simultaneous master 0 load and master 1 store after reset
    k = cyc;
    set_master(0, 0, 1, 0, 32'h300, 32'h0, 2'd0);
    set_master(1, 1, 0, 0, 32'h304, 32'hCAFE_F00D, 2'd3);
    push_iss(0, 32'h300, 32'h0, 2'd0, 0, k + 1);
    push_ack(0, 32'hFFFF_FCFF, k + 4);
    push_iss(1, 32'h304, 32'hCAFE_F00D, 2'd3, 0, k + 6);
    push_ack(1, 32'h0, k + 6);
    wait_ack(0);
    clear_master(0);
    wait_ack(1);
    clear_master(1);
    repeat (4) step();

    chk("ack_q_empty", 32'(ack_q.size()), 32'h0);
    chk("iss_q_empty", 32'(iss_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- N-master memory arbiter between request sources (pipeline, DMA, debug port) and the single memoryController port.
- Replaces the fixed pipeline-to-memoryController connection in soc, so the memory port can be shared.
- Round-robin arbitration, one outstanding transaction at a time.
- Configurable controller read latency; per-master ack handshake; sticky protocol-error flag.

Parameters:
- NUM_MASTERS, 2, number of request ports (>=1).
- DATA_WIDTH, 32, address/data width (matches `DATA_WIDTH).
- READ_LATENCY, 1, cycles from ctrlLoad issue to ctrlDataRead valid (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- mAddress  in  NUM_MASTERS*DATA_WIDTH  per-master address; master i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- mDataWrite  in  NUM_MASTERS*DATA_WIDTH  per-master store data.
- mLength  in  NUM_MASTERS*2  per-master access length, passed through unchanged.
- mStore  in  NUM_MASTERS  per-master store request.
- mLoad  in  NUM_MASTERS  per-master load request.
- mLoadUnsigned  in  NUM_MASTERS  per-master unsigned-load flag.
- mAck  out  NUM_MASTERS  one-cycle completion pulse to the owning master.
- mGrant  out  NUM_MASTERS  one-hot current owner; 0 when idle.
- mDataRead  out  DATA_WIDTH  load data, valid only with a load ack; 0 otherwise.
- protocolError  out  1  sticky flag: some master asserted mStore and mLoad together.
- ctrlAddress  out  DATA_WIDTH  to memoryController addressIn.
- ctrlDataWrite  out  DATA_WIDTH  to memoryController dataWriteIn.
- ctrlLength  out  2  to memoryController length.
- ctrlStore  out  1  to memoryController storeIn.
- ctrlLoad  out  1  to memoryController loadIn.
- ctrlLoadUnsigned  out  1  to memoryController loadUnsigned.
- ctrlDataRead  in  DATA_WIDTH  from memoryController dataReadOut.

Behaviour:
- Interface: single clock clk. reset is synchronous and active-high.
- Reset values:
  - All outputs 0 and state=IDLE.
  - rrPtr=NUM_MASTERS-1, so master 0 wins first.
  - protocolError=0.
  - Wait counter=0.
- Request rule: master i requests when mStore[i]|mLoad[i]. It must hold all fields stable until its mAck[i] is seen.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any request, pick the winner g as the first requesting index searching rrPtr+1, rrPtr+2 ... modulo NUM_MASTERS.
  - Latch g's address, data, length, loadUnsigned and op into issue registers.
  - Set rrPtr=g, mGrant=onehot(g), go to ISSUE.
  - No request: stay in IDLE.
- Op select: if mStore[g] and mLoad[g] are both 1, the op is store and protocolError is set (stays 1 until reset).
  - protocolError is also set if any master, granted or not, shows both bits in any cycle.
- ISSUE (exactly 1 cycle):
  - ctrl* driven from issue registers; ctrlStore or ctrlLoad =1 in this cycle only.
  - Store: mAck[g]=1 this cycle, next state IDLE.
  - Load: counter=READ_LATENCY-1, next state WAIT.
- WAIT:
  - ctrl* data fields stay held; ctrlStore=ctrlLoad=0.
  - Counter decrements each cycle.
  - When counter==0: mAck[g]=1 and mDataRead=ctrlDataRead (combinational pass-through), next state IDLE.
- Latency from request visible in IDLE at cycle T:
  - Store ack at T+1.
  - Load ack at T+1+READ_LATENCY.
- Throughput:
  - Back-to-back requests allowed: IDLE re-arbitrates in the cycle after an ack.
  - Store 2 cycles per transaction; load 2+READ_LATENCY.
- mGrant holds onehot(g) from ISSUE through the ack cycle, then 0 in IDLE.
- Fairness: with all masters continuously requesting, grants rotate 0,1,...,N-1,0. No master waits more than NUM_MASTERS-1 transactions.
- A request withdrawn after capture is still completed and acked (protocol violation, not detected).
- NUM_MASTERS=1: arbitration is degenerate, always g=0.
- Reset mid-transaction: any in-flight transaction is dropped and no ack is issued. All outputs are 0 the cycle after reset.

Test Plan:
- Reset, then master0 store addr 0x100 data 0xDEADBEEF len 2 -> ISSUE shows ctrlStore=1, ctrlAddress=0x100, ctrlDataWrite=0xDEADBEEF; mAck=2'b01 at T+1; mGrant=0 at T+2.
- READ_LATENCY=3, master1 load addr 0x40, model returns 0x12345678 -> ctrlLoad pulses once at T+1; mAck[1] and mDataRead=0x12345678 at T+4; mDataRead=0 at all other cycles.
- NUM_MASTERS=3, all masters continuously storing -> grant order 0,1,2,0,1,2 over six transactions, one ack per 2 cycles.
- Master0 asserts mStore=mLoad=1 -> store performed; protocolError=1 and stays 1 through later clean transactions until reset.
- Reset asserted during WAIT of a load -> no mAck, outputs 0 next cycle; after release, master0 wins first.
- Master0 load and master1 store requested in the same IDLE cycle after reset -> master0 served first, master1 granted in the cycle after master0's ack.
